// File: rtl/instr_encode_loader_pkg.sv
// Shared ISA definitions for the instruction loader: mnemonic codes, MIPS opcode/funct values,
// loader FSM states and field-packing helpers.
package instr_encode_loader_pkg;

  typedef enum logic [4:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpSgt, OpXor, OpNor, OpSll, OpSrl, OpJr,
    OpAddi, OpAndi, OpOri, OpXori, OpSlti, OpLw, OpSw, OpBeq, OpBne, OpJ, OpJal
  } op_e;

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_ADDI  = 6'h08;
  localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
  localparam logic [5:0] OPCODE_ORI   = 6'h0D;
  localparam logic [5:0] OPCODE_XORI  = 6'h0E;
  localparam logic [5:0] OPCODE_SLTI  = 6'h0A;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2B;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_BNE   = 6'h05;
  localparam logic [5:0] OPCODE_J     = 6'h02;
  localparam logic [5:0] OPCODE_JAL   = 6'h03;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_SGT = 6'h29;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_JR  = 6'h08;

  function automatic logic [31:0] pack_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                         logic [4:0] shamt, logic [5:0] funct);
    return {OPCODE_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] pack_i(logic [5:0] opc, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] pack_j(logic [5:0] opc, logic [25:0] target);
    return {opc, target};
  endfunction

endpackage

// File: rtl/instr_encode_loader_if.sv
// Symbolic-instruction stream into the loader (valid/ready with mnemonic and raw fields).
interface instr_encode_loader_if;
  import instr_encode_loader_pkg::*;

  logic        in_valid;
  logic        in_ready;
  op_e         in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
    output in_ready
  );
endinterface

// File: rtl/instr_encode_loader_packer.sv
// Combinational encoder: mnemonic plus raw fields to a 32-bit MIPS word. Fields a format does
// not use are forced to zero; unknown mnemonics yield valid_o = 0.
module instr_encode_loader_packer
  import instr_encode_loader_pkg::*;
(
  input  op_e         op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        valid_o
);

  always_comb begin
    word_o  = '0;
    valid_o = 1'b1;
    case (op_i)
      OpAdd:  word_o = pack_r(rs_i, rt_i, rd_i, 5'd0, FUNCT_ADD);
      OpSub:  word_o = pack_r(rs_i, rt_i, rd_i, 5'd0, FUNCT_SUB);
      OpAnd:  word_o = pack_r(rs_i, rt_i, rd_i, 5'd0, FUNCT_AND);
      OpOr:   word_o = pack_r(rs_i, rt_i, rd_i, 5'd0, FUNCT_OR);
      OpSlt:  word_o = pack_r(rs_i, rt_i, rd_i, 5'd0, FUNCT_SLT);
      OpSgt:  word_o = pack_r(rs_i, rt_i, rd_i, 5'd0, FUNCT_SGT);
      OpXor:  word_o = pack_r(rs_i, rt_i, rd_i, 5'd0, FUNCT_XOR);
      OpNor:  word_o = pack_r(rs_i, rt_i, rd_i, 5'd0, FUNCT_NOR);
      OpSll:  word_o = pack_r(5'd0, rt_i, rd_i, shamt_i, FUNCT_SLL);
      OpSrl:  word_o = pack_r(5'd0, rt_i, rd_i, shamt_i, FUNCT_SRL);
      OpJr:   word_o = pack_r(rs_i, 5'd0, 5'd0, 5'd0, FUNCT_JR);
      OpAddi: word_o = pack_i(OPCODE_ADDI, rs_i, rt_i, imm_i);
      OpAndi: word_o = pack_i(OPCODE_ANDI, rs_i, rt_i, imm_i);
      OpOri:  word_o = pack_i(OPCODE_ORI, rs_i, rt_i, imm_i);
      OpXori: word_o = pack_i(OPCODE_XORI, rs_i, rt_i, imm_i);
      OpSlti: word_o = pack_i(OPCODE_SLTI, rs_i, rt_i, imm_i);
      OpLw:   word_o = pack_i(OPCODE_LW, rs_i, rt_i, imm_i);
      OpSw:   word_o = pack_i(OPCODE_SW, rs_i, rt_i, imm_i);
      OpBeq:  word_o = pack_i(OPCODE_BEQ, rs_i, rt_i, imm_i);
      OpBne:  word_o = pack_i(OPCODE_BNE, rs_i, rt_i, imm_i);
      OpJ:    word_o = pack_j(OPCODE_J, target_i);
      OpJal:  word_o = pack_j(OPCODE_JAL, target_i);
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Boot/test program loader: accepts symbolic instructions, encodes them and writes them to
// consecutive imem words one cycle after acceptance, flagging bad mnemonics and overflow.
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       DEPTH     = 256,
  localparam int unsigned      CntW      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  instr_encode_loader_if.slave in_if,
  output logic                imem_wr_en_o,
  output logic [ADDR_W-1:0]   imem_addr_o,
  output logic [31:0]         imem_wr_data_o,
  output logic [CntW-1:0]     word_count_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_invalid_o,
  output logic                err_full_o
);

  localparam logic [CntW:0] DepthC = (CntW + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              err_inv_q, err_inv_d;
  logic              err_full_q, err_full_d;
  logic [31:0]       packed_word;
  logic              packed_valid;
  logic [CntW:0]     fill;
  logic              full;
  logic              ready;

  instr_encode_loader_packer u_packer (
    .op_i     (in_if.in_op),
    .rs_i     (in_if.in_rs),
    .rt_i     (in_if.in_rt),
    .rd_i     (in_if.in_rd),
    .shamt_i  (in_if.in_shamt),
    .imm_i    (in_if.in_imm),
    .target_i (in_if.in_target),
    .word_o   (packed_word),
    .valid_o  (packed_valid)
  );

  // Occupancy counts the word still in the write register so ready drops on the DEPTH-th accept.
  assign fill = {1'b0, count_q} + {{CntW{1'b0}}, pend_q};
  assign full = (fill >= DepthC);

  always_comb begin
    state_d    = state_q;
    pend_d     = 1'b0;
    word_d     = word_q;
    addr_d     = pend_q ? addr_q + ADDR_W'(4) : addr_q;
    count_d    = count_q + CntW'(pend_q);
    err_inv_d  = err_inv_q;
    err_full_d = err_full_q;
    ready      = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d    = StLoad;
          addr_d     = BASE_ADDR;
          count_d    = '0;
          err_inv_d  = 1'b0;
          err_full_d = 1'b0;
        end
      end
      StLoad: begin
        ready = !full;
        if (in_if.in_valid && !full) begin
          pend_d = packed_valid;
          word_d = packed_word;
          if (!packed_valid) err_inv_d = 1'b1;
          if (in_if.in_last) state_d = StFlush;
        end else if (in_if.in_valid) begin
          err_full_d = 1'b1;
          state_d    = StFlush;
        end
      end
      StFlush: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pend_q     <= 1'b0;
      word_q     <= '0;
      addr_q     <= BASE_ADDR;
      count_q    <= '0;
      err_inv_q  <= 1'b0;
      err_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      err_inv_q  <= err_inv_d;
      err_full_q <= err_full_d;
    end
  end

  assign in_if.in_ready = ready;
  // Reset suppresses a write already sitting in the register, not just the next one.
  assign imem_wr_en_o   = pend_q & ~rst;
  assign imem_addr_o    = addr_q;
  assign imem_wr_data_o = word_q;
  assign word_count_o   = count_q;
  assign busy_o         = (state_q == StLoad) || (state_q == StFlush);
  assign done_o         = (state_q == StDone);
  assign err_invalid_o  = err_inv_q;
  assign err_full_o     = err_full_q;

endmodule
